// File: rtl/ps2_host_tx.sv
// ============================================================================
// Module   : ps2_host_tx
// Brief    : PS/2 host-to-device command transmitter (open-drain line drive).
//            Optional glitch filter on the synchronised pins: PS2_TX_GLITCH_FILTER_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] tx_err_code,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int c_cnt_max = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam bit c_filter_en = 1'b1;
`else
    localparam bit c_filter_en = 1'b0;
`endif

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_inhibit   = 3'd1;
    localparam logic [2:0] c_st_req       = 3'd2;
    localparam logic [2:0] c_st_shift     = 3'd3;
    localparam logic [2:0] c_st_ack       = 3'd4;
    localparam logic [2:0] c_st_wait_idle = 3'd5;

    localparam logic [1:0] c_err_timeout = 2'b01;
    localparam logic [1:0] c_err_no_ack  = 2'b10;

    logic [1:0]         r_clk_sync;
    logic [1:0]         r_data_sync;
    logic [1:0]         w_sync;
    logic [1:0]         w_line;   // [0] clock, [1] data
    logic               r_clk_prev;
    logic               w_fe;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_cnt_clr;
    logic               w_timeout;
    logic [3:0]         r_bit_cnt;
    logic [3:0]         w_bit_next;
    logic [2:0]         w_bit_idx;
    logic [7:0]         r_byte;
    logic               r_parity;
    logic               w_accept;
    logic               r_done;
    logic               w_done_next;
    logic               r_error;
    logic               w_error_next;
    logic [1:0]         r_err_code;
    logic [1:0]         w_err_code_next;
    logic               w_data_oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk_in};
            r_data_sync <= {r_data_sync[0], ps2_data_in};
        end
    end

    assign w_sync = {r_data_sync[1], r_clk_sync[1]};

    generate
        if (c_filter_en) begin : g_filter
            localparam int c_fw = $clog2(FILTER_LEN + 1);
            for (genvar i = 0; i < 2; i++) begin : g_line
                logic [c_fw-1:0] r_flt_cnt;
                logic            r_flt_out;
                // Output follows the input only after FILTER_LEN consecutive differing samples
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_flt_cnt <= '0;
                        r_flt_out <= 1'b1;
                    end else if (w_sync[i] == r_flt_out) begin
                        r_flt_cnt <= '0;
                    end else if (r_flt_cnt == c_fw'(FILTER_LEN - 1)) begin
                        r_flt_cnt <= '0;
                        r_flt_out <= w_sync[i];
                    end else begin
                        r_flt_cnt <= r_flt_cnt + 1'b1;
                    end
                end
                assign w_line[i] = r_flt_out;
            end
        end else begin : g_bypass
            assign w_line = w_sync;
        end
    endgenerate

    assign w_fe      = r_clk_prev & ~w_line[0];
    assign w_accept  = (r_state == c_st_idle) && tx_valid;
    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1)) && !w_fe;
    assign w_bit_idx = r_bit_cnt[2:0] - 3'd1;

    always_comb begin
        w_state_next    = r_state;
        w_bit_next      = r_bit_cnt;
        w_done_next     = 1'b0;
        w_error_next    = 1'b0;
        w_err_code_next = r_err_code;
        case (r_state)
            c_st_idle: begin
                if (tx_valid) begin
                    w_state_next    = c_st_inhibit;
                    w_bit_next      = 4'd0;
                    w_err_code_next = 2'b00;
                end
            end
            c_st_inhibit: begin
                if (r_cnt == c_cnt_w'(INHIBIT_CYCLES - 1)) w_state_next = c_st_req;
            end
            c_st_req: begin
                if (w_fe) begin
                    w_bit_next   = 4'd1;
                    w_state_next = c_st_shift;
                end
            end
            c_st_shift: begin
                if (w_fe) begin
                    w_bit_next = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd9) w_state_next = c_st_ack;
                end
            end
            c_st_ack: begin
                if (w_fe) begin
                    w_state_next = c_st_wait_idle;
                    if (w_line[1]) begin
                        w_error_next    = 1'b1;
                        w_err_code_next = c_err_no_ack;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            c_st_wait_idle: begin
                if (w_line[0] && w_line[1]) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
        // A stalled device aborts any waiting state, overriding its own transition
        if ((r_state == c_st_req || r_state == c_st_shift || r_state == c_st_ack ||
             r_state == c_st_wait_idle) && w_timeout) begin
            w_state_next    = c_st_idle;
            w_done_next     = 1'b0;
            w_error_next    = 1'b1;
            w_err_code_next = c_err_timeout;
        end
    end

    // Our own clock pull-down would look like an edge, so INHIBIT ignores fe
    assign w_cnt_clr = (w_state_next != r_state) || (w_fe && r_state != c_st_inhibit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_cnt      <= '0;
            r_bit_cnt  <= 4'd0;
            r_byte     <= 8'h00;
            r_parity   <= 1'b0;
            r_clk_prev <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_next;
            r_clk_prev <= w_line[0];
            r_done     <= w_done_next;
            r_error    <= w_error_next;
            r_err_code <= w_err_code_next;
            if (w_cnt_clr)   r_cnt <= '0;
            else if (~&r_cnt) r_cnt <= r_cnt + 1'b1;
            if (w_accept) begin
                r_byte   <= tx_data;
                r_parity <= ~^tx_data;
            end
        end
    end

    always_comb begin
        w_data_oe = 1'b0;
        case (r_state)
            c_st_inhibit: w_data_oe = (r_cnt == c_cnt_w'(INHIBIT_CYCLES - 1));
            c_st_req:     w_data_oe = 1'b1;
            c_st_shift: begin
                if (r_bit_cnt <= 4'd8)      w_data_oe = ~r_byte[w_bit_idx];
                else if (r_bit_cnt == 4'd9) w_data_oe = ~r_parity;
            end
            default:      w_data_oe = 1'b0;
        endcase
    end

    assign ps2_clk_oe  = (r_state == c_st_inhibit);
    assign ps2_data_oe = w_data_oe;
    assign tx_ready    = (r_state == c_st_idle);
    assign tx_done     = r_done;
    assign tx_error    = r_error;
    assign tx_err_code = r_err_code;

endmodule

`default_nettype wire
